// File: rtl/carfield_periph_apb_demux.sv
// APB demultiplexer for the Carfield peripheral segment: address decode, registered
// downstream request, local decode errors, access timeout and first-error capture.
module carfield_periph_apb_demux #(
    parameter int unsigned NumSlv        = 5,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvBase = {32'h20009000, 32'h20007000,
                                                           32'h20005000, 32'h20004000,
                                                           32'h20001000},
    parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvSize = {5{32'h00001000}},
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          psel_i,
    input  logic                          penable_i,
    input  logic [AddrWidth-1:0]          paddr_i,
    input  logic                          pwrite_i,
    input  logic [DataWidth-1:0]          pwdata_i,
    input  logic [DataWidth/8-1:0]        pstrb_i,
    output logic [DataWidth-1:0]          prdata_o,
    output logic                          pready_o,
    output logic                          pslverr_o,
    output logic [NumSlv-1:0]             psel_o,
    output logic                          penable_o,
    output logic [AddrWidth-1:0]          paddr_o,
    output logic                          pwrite_o,
    output logic [DataWidth-1:0]          pwdata_o,
    output logic [DataWidth/8-1:0]        pstrb_o,
    input  logic [NumSlv*DataWidth-1:0]   prdata_i,
    input  logic [NumSlv-1:0]             pready_i,
    input  logic [NumSlv-1:0]             pslverr_i,
    output logic                          err_valid_o,
    output logic [1:0]                    err_code_o,
    output logic [AddrWidth-1:0]          err_addr_o,
    input  logic                          err_clear_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxW      = (NumSlv > 1) ? $clog2(NumSlv) : 1;
    localparam int unsigned CntW      = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [1:0] ErrDecode  = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;
    localparam logic [1:0] ErrSlave   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DECERR
    } state_e;

    state_e                 r_state;
    logic [IdxW-1:0]        r_idx;
    logic [CntW-1:0]        r_cnt;
    logic [NumSlv-1:0]      r_psel;
    logic                   r_penable;
    logic [AddrWidth-1:0]   r_paddr;
    logic                   r_pwrite;
    logic [DataWidth-1:0]   r_pwdata;
    logic [StrbWidth-1:0]   r_pstrb;
    logic                   r_err_valid;
    logic [1:0]             r_err_code;
    logic [AddrWidth-1:0]   r_err_addr;

    state_e                 w_state_nxt;
    logic [IdxW-1:0]        w_idx_nxt;
    logic [CntW-1:0]        w_cnt_nxt;
    logic [NumSlv-1:0]      w_psel_nxt;
    logic                   w_latch;
    logic                   w_hit;
    logic [IdxW-1:0]        w_hit_idx;
    logic                   w_pready;
    logic                   w_pslverr;
    logic [DataWidth-1:0]   w_prdata;
    logic                   w_err_evt;
    logic [1:0]             w_err_code;
    logic                   w_timeout;
    logic [NumSlv-1:0][DataWidth-1:0] w_prdata_arr;

    assign w_prdata_arr = prdata_i;
    assign w_timeout    = (r_cnt == CntW'(TimeoutCycles - 1));

    // Address decode; the descending scan lets the lowest matching index win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NumSlv - 1; i >= 0; i--) begin
            if ((SlvSize[i] != '0) &&
                ({1'b0, paddr_i} >= {1'b0, SlvBase[i]}) &&
                ({1'b0, paddr_i} <  ({1'b0, SlvBase[i]} + {1'b0, SlvSize[i]}))) begin
                w_hit     = 1'b1;
                w_hit_idx = IdxW'(i);
            end
        end
    end

    // Next state, counter and upstream response.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = '0;
        w_latch     = 1'b0;
        w_pready    = 1'b0;
        w_pslverr   = 1'b0;
        w_prdata    = '0;
        w_err_evt   = 1'b0;
        w_err_code  = '0;
        case (r_state)
            S_IDLE: begin
                if (psel_i && !penable_i) begin
                    w_latch = 1'b1;
                    if (w_hit) begin
                        w_state_nxt = S_SETUP;
                        w_idx_nxt   = w_hit_idx;
                    end else begin
                        w_state_nxt = S_DECERR;
                    end
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (pready_i[r_idx]) begin
                    w_state_nxt = S_IDLE;
                    w_pready    = 1'b1;
                    w_pslverr   = pslverr_i[r_idx];
                    w_prdata    = w_prdata_arr[r_idx];
                    w_err_evt   = pslverr_i[r_idx];
                    w_err_code  = ErrSlave;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_pready    = 1'b1;
                    w_pslverr   = 1'b1;
                    w_err_evt   = 1'b1;
                    w_err_code  = ErrTimeout;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            S_DECERR: begin
                w_state_nxt = S_IDLE;
                w_pready    = 1'b1;
                w_pslverr   = 1'b1;
                w_err_evt   = 1'b1;
                w_err_code  = ErrDecode;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_psel_nxt = '0;
        if ((w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS)) begin
            w_psel_nxt = NumSlv'(1) << w_idx_nxt;
        end
    end

    // A response to an upstream master that already dropped PSEL is discarded.
    assign pready_o  = w_pready & psel_i;
    assign pslverr_o = w_pslverr & psel_i;
    assign prdata_o  = psel_i ? w_prdata : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
            r_err_addr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= (w_state_nxt == S_ACCESS);
            if (w_latch) begin
                r_paddr  <= paddr_i;
                r_pwrite <= pwrite_i;
                r_pwdata <= pwdata_i;
                r_pstrb  <= pstrb_i;
            end
            // A new error wins over a simultaneous clear.
            if (w_err_evt && (!r_err_valid || err_clear_i)) begin
                r_err_valid <= 1'b1;
                r_err_code  <= w_err_code;
                r_err_addr  <= r_paddr;
            end else if (err_clear_i) begin
                r_err_valid <= 1'b0;
                r_err_code  <= '0;
                r_err_addr  <= '0;
            end
        end
    end

    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign paddr_o     = r_paddr;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;
    assign pstrb_o     = r_pstrb;
    assign err_valid_o = r_err_valid;
    assign err_code_o  = r_err_code;
    assign err_addr_o  = r_err_addr;

endmodule

// File: doc/carfield_periph_apb_demux.md
Name: carfield_periph_apb_demux

Overview:
- APB demultiplexer for the peripheral APB segment, directly downstream of the AXI-to-APB bridge.
- Decodes each upstream APB transfer against the APB address map and forwards it to one of NumSlv downstream APB peripherals: CAN, system timer, advanced timer, watchdog and HyperBus config.
- Registers the downstream request.
- Answers unmapped addresses locally with PSLVERR.
- Terminates hung peripherals with a timeout.
- Captures the first error for software.

Parameters:
- NumSlv, 5, number of downstream APB ports.
- AddrWidth, 32, APB address width.
- DataWidth, 32, APB data width.
- SlvBase, {'h20009000,'h20007000,'h20005000,'h20004000,'h20001000}, per-port base address; index 0 = CAN.
- SlvSize, {5{'h1000}}, per-port region size; a size of 0 disables that port.
- TimeoutCycles, 256, maximum ACCESS cycles allowed before forced termination; must be ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- psel_i  in  1  upstream PSEL.
- penable_i  in  1  upstream PENABLE.
- paddr_i  in  AddrWidth  upstream address.
- pwrite_i  in  1  upstream write.
- pwdata_i  in  DataWidth  upstream write data.
- pstrb_i  in  DataWidth/8  upstream strobes.
- prdata_o  out  DataWidth  upstream read data.
- pready_o  out  1  upstream ready.
- pslverr_o  out  1  upstream error.
- psel_o  out  NumSlv  one-hot downstream select.
- penable_o  out  1  downstream enable.
- paddr_o  out  AddrWidth  downstream address, registered.
- pwrite_o  out  1  downstream write, registered.
- pwdata_o  out  DataWidth  downstream write data, registered.
- pstrb_o  out  DataWidth/8  downstream strobes, registered.
- prdata_i  in  NumSlv*DataWidth  downstream read data.
- pready_i  in  NumSlv  downstream ready.
- pslverr_i  in  NumSlv  downstream error.
- err_valid_o  out  1  sticky error flag.
- err_code_o  out  2  error code: 01 decode, 10 timeout, 11 slave PSLVERR.
- err_addr_o  out  AddrWidth  address of the captured error.
- err_clear_i  in  1  clears the captured error.

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Decode: hit on port i when SlvSize[i]≠0 and SlvBase[i] ≤ paddr_i < SlvBase[i]+SlvSize[i]. Compute the sum at AddrWidth+1 bits, so there is no wrap at the top of the address space. Overlapping regions: the lowest index wins.
- FSM IDLE: on psel_i & !penable_i, latch addr/write/wdata/strb into the downstream registers.
  - On a hit, latch idx and go to SETUP.
  - On a miss, go to DECERR.
- FSM SETUP (1 cycle): psel_o[idx]=1, penable_o=0. Go to ACCESS.
- FSM ACCESS: psel_o[idx]=1, penable_o=1, and the counter increments every cycle.
  - pready_o = pready_i[idx], combinational; prdata_o and pslverr_o are muxed from port idx and are valid only while pready_o=1.
  - When pready_i[idx]=1, go to IDLE and clear the counter.
  - When the counter reaches TimeoutCycles-1 with pready_i[idx]=0, drive pready_o=1, pslverr_o=1, prdata_o=0 in that cycle. Deassert psel_o and penable_o on the next edge and go to IDLE.
- FSM DECERR (1 cycle): psel_o=0, pready_o=1, pslverr_o=1, prdata_o=0. Go to IDLE.
- Latency: minimum upstream transfer is 3 cycles (upstream SETUP at T0, downstream SETUP at T1, ACCESS with pready at T2). A decode error completes at T1.
- Outside ACCESS/DECERR: pready_o=0, pslverr_o=0, prdata_o=0.
- Downstream is never selected outside SETUP/ACCESS. At most one psel_o bit is set at any time.
- Upstream psel_i dropping mid-transfer (protocol violation): the downstream transfer still completes or times out normally; the response is discarded. No new request is accepted until IDLE.
- Error capture:
  - When err_valid_o=0, the first decode error, timeout, or completion with pslverr_i[idx]=1 sets err_valid_o and loads err_code_o and err_addr_o (the latched address).
  - While err_valid_o=1, further errors are ignored.
  - err_clear_i clears err_valid_o, err_code_o and err_addr_o on the next edge. If an error occurs in the same cycle as err_clear_i, the new error is captured, because capture has priority over clear.
- Reset mid-transfer: psel_o and penable_o are 0 after the reset edge; no response is given upstream; error state is cleared.

Test Plan:
- Write to 'h20007010 with pready_i[3] high on the first ACCESS cycle → psel_o=5'b01000 at T1, penable_o=1 at T2, pready_o=1 at T2, pwdata_o equal to the upstream data, no error.
- Read from 'h20001FFC, CAN inserts 4 wait states then returns 'hDEADBEEF → pready_o rises at T6, prdata_o='hDEADBEEF, pslverr_o=0.
- Access to 'h20002000 (unmapped) → psel_o stays 0, pready_o=pslverr_o=1 at T1, prdata_o=0, err_valid_o=1, err_code_o=01, err_addr_o='h20002000.
- Watchdog never asserts pready with TimeoutCycles=256 → pready_o=pslverr_o=1 on the 256th ACCESS cycle, psel_o=0 on the next cycle, err_code_o=10.
- Timer asserts pslverr_i[1] while err_valid_o is already set → upstream pslverr_o=1, captured err_addr_o unchanged. Assert err_clear_i together with a new decode error → err_valid_o remains 1 with the new address.
- Assert rst_i during a timer-port ACCESS → next cycle all outputs 0. The next transfer decodes normally with no stale counter value.
